mem_stage_sram: RTL and testbench
=================================

Name: mem_stage_sram

Overview:
- Memory stage of the 5-stage pipeline. Consumes the execute stage's ALU result, store data, control bits and destination register, and produces the registered MEM/WB bundle.
- Loads and stores go to an external 16-bit SRAM. Each 32-bit word takes two half-word accesses, each with programmable wait states.
- While an access is in flight, `freeze` stalls every upstream stage.

Parameters:
- SRAM_AW, 18, SRAM half-word address width. Word address is alu_result[SRAM_AW:2].
- SRAM_WAIT, 1, extra wait cycles per half-word access. Legal range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wb_en  in  1  writeback enable from execute.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- alu_result  in  32  effective address, or ALU value for non-memory ops.
- reg2  in  32  store data.
- dest  in  5  destination register.
- freeze  out  1  stall for the PC and all upstream pipeline registers.
- wb_en_out  out  1  registered wb_en.
- mem_read_out  out  1  registered mem_read; selects the WB mux.
- alu_result_out  out  32  registered alu_result.
- mem_data_out  out  32  registered load data.
- dest_out  out  5  registered dest.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_wdata  out  16  SRAM write data.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_rdata  in  16  SRAM read data, valid on the last wait cycle of a phase.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; wait counter 0.
  - All registered outputs 0; sram_we_n=1; sram_addr=0; sram_wdata=0.
  - freeze=0 while in reset.
- Request: req = mem_read | mem_write. If both are high, the access is a store; mem_read_out still registers the raw input.
- States and transitions:
  - IDLE: if req, go to LO. Otherwise stay in IDLE and load the MEM/WB register.
  - LO: sram_addr = {word_addr, 1'b0}. Count SRAM_WAIT+1 cycles. On the last cycle, a load latches sram_rdata into data_lo. Then go to HI.
  - HI: sram_addr = {word_addr, 1'b1}. Count SRAM_WAIT+1 cycles. On the last cycle, a load latches sram_rdata into data_hi. Then go to DONE.
  - DONE: one cycle, then IDLE.
- Stores: sram_we_n=0 for every cycle of LO and HI. sram_wdata = reg2[15:0] in LO and reg2[31:16] in HI.
- Non-access cycles: sram_we_n=1 in IDLE and DONE and for loads. sram_addr is held at its last value; sram_wdata=0.
- freeze is combinational: freeze = req & (state != DONE). It is high in the IDLE cycle where a request first appears, and throughout LO and HI.
- Stall length: exactly 2*(SRAM_WAIT+1)+1 frozen cycles per access, then DONE with freeze=0.
- MEM/WB register:
  - Loads on the rising edge whenever freeze=0, i.e. in IDLE without a request, or in DONE.
  - mem_data_out loads {data_hi, data_lo} in DONE, and 0 for non-memory instructions.
  - While freeze=1 the register holds its value. Re-writing the same WB target is harmless.
- Back-to-back accesses: after DONE the upstream register advances. The next cycle is IDLE with the new instruction; a new req restarts at LO with no gap beyond that IDLE cycle.
- Inputs must be stable while freeze=1; this is guaranteed by upstream stalling.
- Reset mid-access: the access is abandoned immediately and sram_we_n returns to 1. The SRAM holds no partial-store guarantee.
- Addresses wrap modulo 2^SRAM_AW half-words; alu_result[1:0] and the bits above SRAM_AW are ignored.

Decomposition:
- Shared pipeline package holds:
  - state encoding: IDLE=0, LO=1, HI=2, DONE=3;
  - the MEM/WB bundle typedef (wb_en, mem_read, alu_result, mem_data, dest);
  - the register-index width constant (5).
- One natural sub-module, sram_ctrl: FSM, wait counter, and SRAM pins plus the 32-bit assembled read word.
- The MEM/WB register stays in the top.

Test Plan:
- Reset: rst=0 mid-run → all outputs 0, sram_we_n=1 and freeze=0 within the same cycle, asynchronously.
- Store with SRAM_WAIT=1: alu_result=0x0000_0010, reg2=0xDEAD_BEEF →
  - sram_addr=0x8, wdata=0xBEEF, we_n=0 for 2 cycles;
  - then sram_addr=0x9, wdata=0xDEAD for 2 cycles;
  - freeze high for exactly 5 cycles.
- Load from the same address: SRAM model returns 0xBEEF/0xDEAD → after DONE, mem_data_out=0xDEADBEEF, mem_read_out=1, dest_out matches.
- Non-memory op: wb_en=1, alu_result=0x1234, dest=7 → freeze never asserts; alu_result_out=0x1234 and dest_out=7 one clock later; mem_data_out=0.
- Back-to-back load→store, plus SRAM_WAIT=0 variant → each access freezes for exactly 2*SRAM_WAIT+3 cycles (3 at SRAM_WAIT=0); exactly one IDLE cycle separates them; no we_n glitch during the load.
- mem_read=mem_write=1 with rst pulsed low during HI → the access is performed as a store; after reset, state=IDLE and we_n=1.

Source files
------------

// File: rtl/mem_stage_sram_pkg.sv
// Shared pipeline types for the memory stage: FSM encoding and the MEM/WB bundle.
package mem_stage_sram_pkg;

  localparam int unsigned RegAw = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef struct packed {
    logic             wb_en;
    logic             mem_read;
    logic [31:0]      alu_result;
    logic [31:0]      mem_data;
    logic [RegAw-1:0] dest;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// 16-bit SRAM sequencer: splits a 32-bit word access into low and high half-word
// phases, each lasting SramWait+1 cycles, and assembles the read word.
module mem_stage_sram_ctrl
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned SramAw   = 18,
  parameter int unsigned SramWait = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              store_i,
  input  logic              load_i,
  input  logic [SramAw-2:0] word_addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [15:0]       sram_rdata_i,
  output state_e            state_o,
  output logic [31:0]       rdata_o,
  output logic [SramAw-1:0] sram_addr_o,
  output logic [15:0]       sram_wdata_o,
  output logic              sram_we_no
);

  localparam logic [2:0] WaitLast = 3'(SramWait);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [15:0]       lo_q, lo_d, hi_q, hi_d;
  logic [SramAw-1:0] addr_q;

  // State, wait counter, read halves and last driven address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      addr_q  <= sram_addr_o;
    end
  end

  // Next state: each phase ends on its last wait cycle, where read data is valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = StLo;
          cnt_d   = '0;
        end
      end
      StLo: begin
        if (cnt_q == WaitLast) begin
          state_d = StHi;
          cnt_d   = '0;
          if (load_i) lo_d = sram_rdata_i;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StHi: begin
        if (cnt_q == WaitLast) begin
          state_d = StDone;
          cnt_d   = '0;
          if (load_i) hi_d = sram_rdata_i;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // SRAM pins: address is held between accesses so the bus stays quiet.
  always_comb begin
    sram_addr_o  = addr_q;
    sram_wdata_o = '0;
    sram_we_no   = 1'b1;
    unique case (state_q)
      StLo: begin
        sram_addr_o = {word_addr_i, 1'b0};
        if (store_i) begin
          sram_we_no   = 1'b0;
          sram_wdata_o = wdata_i[15:0];
        end
      end
      StHi: begin
        sram_addr_o = {word_addr_i, 1'b1};
        if (store_i) begin
          sram_we_no   = 1'b0;
          sram_wdata_o = wdata_i[31:16];
        end
      end
      default: ;
    endcase
  end

  assign state_o = state_q;
  assign rdata_o = {hi_q, lo_q};

endmodule

// File: rtl/mem_stage_sram.sv
// Memory pipeline stage: drives the external 16-bit SRAM, stalls upstream while an
// access is in flight, and holds the MEM/WB register.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned SRAM_AW   = 18,
  parameter int unsigned SRAM_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        reg2,
  input  logic [RegAw-1:0]   dest,
  output logic               freeze,
  output logic               wb_en_out,
  output logic               mem_read_out,
  output logic [31:0]        alu_result_out,
  output logic [31:0]        mem_data_out,
  output logic [RegAw-1:0]   dest_out,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  output logic               sram_we_n,
  input  logic [15:0]        sram_rdata
);

  logic        req;
  state_e      state;
  logic [31:0] rd_word;
  mem_wb_t     wb_d, wb_q;

  assign req = mem_read | mem_write;

  // A simultaneous read and write request is treated as a store.
  mem_stage_sram_ctrl #(
    .SramAw  (SRAM_AW),
    .SramWait(SRAM_WAIT)
  ) u_ctrl (
    .clk_i       (clk),
    .rst_ni      (rst),
    .req_i       (req),
    .store_i     (mem_write),
    .load_i      (mem_read & ~mem_write),
    .word_addr_i (alu_result[SRAM_AW:2]),
    .wdata_i     (reg2),
    .sram_rdata_i(sram_rdata),
    .state_o     (state),
    .rdata_o     (rd_word),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_we_no  (sram_we_n)
  );

  // Stall from the first request cycle until DONE; forced low while reset is held.
  assign freeze = rst & req & (state != StDone);

  // MEM/WB next value: load data only exists in DONE, zero otherwise.
  always_comb begin
    wb_d            = '0;
    wb_d.wb_en      = wb_en;
    wb_d.mem_read   = mem_read;
    wb_d.alu_result = alu_result;
    wb_d.mem_data   = (state == StDone) ? rd_word : 32'd0;
    wb_d.dest       = dest;
  end

  // MEM/WB register advances whenever the pipeline is not frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (!freeze) begin
      wb_q <= wb_d;
    end
  end

  assign wb_en_out      = wb_q.wb_en;
  assign mem_read_out   = wb_q.mem_read;
  assign alu_result_out = wb_q.alu_result;
  assign mem_data_out   = wb_q.mem_data;
  assign dest_out       = wb_q.dest;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram: instance A runs with one wait state, instance B
// with none; each has a small behavioural SRAM behind it.
module tb_mem_stage_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en, mem_read, mem_write, sel_b;
  logic [31:0] alu_result, reg2;
  logic [4:0]  dest;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A signals
  logic        freeze_a, wb_en_out_a, mem_read_out_a, we_n_a;
  logic [31:0] alu_out_a, data_out_a;
  logic [4:0]  dest_out_a;
  logic [17:0] addr_a;
  logic [15:0] wdata_a, rdata_a;
  // Instance B signals
  logic        freeze_b, wb_en_out_b, mem_read_out_b, we_n_b;
  logic [31:0] alu_out_b, data_out_b;
  logic [4:0]  dest_out_b;
  logic [17:0] addr_b;
  logic [15:0] wdata_b, rdata_b;

  logic [15:0] sram_a [256];
  logic [15:0] sram_b [256];

  // Selected-instance views
  logic        fz, we_n, o_wb_en, o_mem_read;
  logic [17:0] addr;
  logic [15:0] wdata;
  logic [31:0] o_alu, o_data;
  logic [4:0]  o_dest;

  always #5 clk = ~clk;

  mem_stage_sram #(.SRAM_AW(18), .SRAM_WAIT(1)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .wb_en         (wb_en),
    .mem_read      (mem_read & ~sel_b),
    .mem_write     (mem_write & ~sel_b),
    .alu_result    (alu_result),
    .reg2          (reg2),
    .dest          (dest),
    .freeze        (freeze_a),
    .wb_en_out     (wb_en_out_a),
    .mem_read_out  (mem_read_out_a),
    .alu_result_out(alu_out_a),
    .mem_data_out  (data_out_a),
    .dest_out      (dest_out_a),
    .sram_addr     (addr_a),
    .sram_wdata    (wdata_a),
    .sram_we_n     (we_n_a),
    .sram_rdata    (rdata_a)
  );

  mem_stage_sram #(.SRAM_AW(18), .SRAM_WAIT(0)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .wb_en         (wb_en),
    .mem_read      (mem_read & sel_b),
    .mem_write     (mem_write & sel_b),
    .alu_result    (alu_result),
    .reg2          (reg2),
    .dest          (dest),
    .freeze        (freeze_b),
    .wb_en_out     (wb_en_out_b),
    .mem_read_out  (mem_read_out_b),
    .alu_result_out(alu_out_b),
    .mem_data_out  (data_out_b),
    .dest_out      (dest_out_b),
    .sram_addr     (addr_b),
    .sram_wdata    (wdata_b),
    .sram_we_n     (we_n_b),
    .sram_rdata    (rdata_b)
  );

  always @(posedge clk) if (!we_n_a) sram_a[addr_a[7:0]] <= wdata_a;
  always @(posedge clk) if (!we_n_b) sram_b[addr_b[7:0]] <= wdata_b;
  assign rdata_a = sram_a[addr_a[7:0]];
  assign rdata_b = sram_b[addr_b[7:0]];

  assign fz         = sel_b ? freeze_b       : freeze_a;
  assign we_n       = sel_b ? we_n_b         : we_n_a;
  assign addr       = sel_b ? addr_b         : addr_a;
  assign wdata      = sel_b ? wdata_b        : wdata_a;
  assign o_wb_en    = sel_b ? wb_en_out_b    : wb_en_out_a;
  assign o_mem_read = sel_b ? mem_read_out_b : mem_read_out_a;
  assign o_alu      = sel_b ? alu_out_b      : alu_out_a;
  assign o_data     = sel_b ? data_out_b     : data_out_a;
  assign o_dest     = sel_b ? dest_out_b     : dest_out_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic rd,
                        input logic [31:0] alu, input logic [4:0] dst);
    chk({tag, "_wb_en"}, 32'(o_wb_en), 32'(en));
    chk({tag, "_mem_read"}, 32'(o_mem_read), 32'(rd));
    chk({tag, "_alu"}, o_alu, alu);
    chk({tag, "_dest"}, 32'(o_dest), 32'(dst));
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_freeze"}, 32'(freeze_a), 32'd0);
    chk({tag, "_we_n"}, 32'(we_n_a), 32'd1);
    chk({tag, "_addr"}, 32'(addr_a), 32'd0);
    chk({tag, "_wdata"}, 32'(wdata_a), 32'd0);
    chk({tag, "_outs"}, {wb_en_out_a, mem_read_out_a, dest_out_a, 25'd0}, 32'd0);
    chk({tag, "_alu_out"}, alu_out_a, 32'd0);
    chk({tag, "_data_out"}, data_out_a, 32'd0);
  endtask

  // Present a memory instruction at the current negedge and follow it until DONE,
  // checking SRAM pins every frozen cycle and the stall length.
  task automatic access(input bit b, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] dst, input int w);
    int          k;
    bit          hi;
    logic [31:0] ea, ewd;
    sel_b = b; mem_read = rd; mem_write = wr; wb_en = rd;
    alu_result = a; reg2 = d; dest = dst;
    k = 0;
    #1;
    while (fz && k < 40) begin
      if (k == 0) begin
        chk("idle_we_n", 32'(we_n), 32'd1);
        chk("idle_wdata", 32'(wdata), 32'd0);
      end else begin
        hi  = (k > w + 1);
        ea  = (((a >> 2) << 1) | 32'(hi)) & 32'h3FFFF;
        ewd = !wr ? 32'd0 : (hi ? {16'd0, d[31:16]} : {16'd0, d[15:0]});
        chk(hi ? "hi_addr" : "lo_addr", 32'(addr), ea);
        chk(hi ? "hi_we_n" : "lo_we_n", 32'(we_n), 32'(!wr));
        chk(hi ? "hi_wdata" : "lo_wdata", 32'(wdata), ewd);
      end
      k++;
      @(negedge clk);
      #1;
    end
    chk("freeze_len", 32'(k), 32'(2 * w + 3));
    chk("done_we_n", 32'(we_n), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sel_b = 1'b0; wb_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    alu_result = '0; reg2 = '0; dest = '0;
    #3;
    chk_reset_a("rst0");
    chk("rst0_b_we_n", 32'(we_n_b), 32'd1);
    chk("rst0_b_freeze", 32'(freeze_b), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Non-memory op passes through in one clock without stalling.
    @(negedge clk);
    wb_en = 1'b1; alu_result = 32'h0000_1234; dest = 5'd7;
    #1;
    chk("alu_freeze", 32'(fz), 32'd0);
    @(negedge clk);
    chk("alu_freeze_after", 32'(fz), 32'd0);
    chk_wb("alu", 1'b1, 1'b0, 32'h0000_1234, 5'd7);
    chk("alu_mem_data", o_data, 32'd0);

    // Store then load back, one wait state.
    access(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd3, 1);
    @(negedge clk);
    chk_wb("st", 1'b0, 1'b0, 32'h0000_0010, 5'd3);
    chk("sram_lo_word", 32'(sram_a[8]), 32'h0000_BEEF);
    chk("sram_hi_word", 32'(sram_a[9]), 32'h0000_DEAD);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd5, 1);
    @(negedge clk);
    chk_wb("ld", 1'b1, 1'b1, 32'h0000_0010, 5'd5);
    chk("ld_mem_data", o_data, 32'hDEAD_BEEF);
    // Back-to-back store right after the load.
    access(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 5'd6, 1);
    @(negedge clk);
    chk_wb("b2b_st", 1'b0, 1'b0, 32'h0000_0020, 5'd6);
    chk("b2b_sram_hi", 32'(sram_a[8'h11]), 32'h0000_0BAD);

    // Zero wait states on instance B: store then load back-to-back.
    access(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_BABE, 5'd8, 0);
    @(negedge clk);
    chk_wb("w0_st", 1'b0, 1'b0, 32'h0000_0040, 5'd8);
    access(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd9, 0);
    @(negedge clk);
    chk_wb("w0_ld", 1'b1, 1'b1, 32'h0000_0040, 5'd9);
    chk("w0_ld_mem_data", o_data, 32'hCAFE_BABE);
    sel_b = 1'b0; mem_read = 1'b0; mem_write = 1'b0; wb_en = 1'b0;

    // Read+write together is a store; reset lands mid-HI phase.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b1; wb_en = 1'b1;
    alu_result = 32'h0000_0030; reg2 = 32'h1234_5678; dest = 5'd2;
    #1;
    chk("rw_idle_freeze", 32'(freeze_a), 32'd1);
    @(negedge clk); #1;
    chk("rw_lo_we_n", 32'(we_n_a), 32'd0);
    chk("rw_lo_wdata", 32'(wdata_a), 32'h0000_5678);
    @(negedge clk);
    @(negedge clk); #1;
    chk("rw_hi_addr", 32'(addr_a), 32'h0000_0019);
    chk("rw_hi_wdata", 32'(wdata_a), 32'h0000_1234);
    chk("rw_hi_we_n", 32'(we_n_a), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_a("rst_mid");
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    // Full access from IDLE proves the FSM restarted cleanly.
    access(1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'h1234_5678, 5'd2, 1);
    @(negedge clk);
    chk_wb("rw", 1'b1, 1'b1, 32'h0000_0030, 5'd2);
    chk("rw_sram_hi", 32'(sram_a[8'h19]), 32'h0000_1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
